// File: rtl/sysa_drain.sv
// sysa_drain: de-skews the systolic array's bottom-row outputs into whole rows and queues them on a valid/ready stream.
// Optional macro SYSA_DRAIN_SAT_EN: clamp each column to 8 bits (255) when a row is pushed.
module sysa_drain #(
  parameter int N      = 3,
  parameter int ACC_W  = 10,
  parameter int ROWS_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                start,
  input  logic [ROWS_W-1:0]   rows,
  input  logic [N*ACC_W-1:0]  down_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N*ACC_W-1:0]  out_data,
  output logic                out_last,
  output logic                hold,
  output logic                busy,
  output logic                ovf
);
  localparam int SW = ROWS_W + $clog2(N) + 1;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [SW-1:0] NM1 = SW'(N - 1);

  typedef enum logic {IDLE, CAPTURE} state_t;

  state_t              r_state, w_state_nxt;
  logic [SW-1:0]       r_s, w_scur;
  logic [ROWS_W-1:0]   r_m, w_m;
  logic                w_go, w_step, w_push, w_last;
  logic                w_pop, w_full, w_wr;
  logic [N*ACC_W-1:0]  w_row, w_wdata;
  logic [N*ACC_W-1:0]  r_mem [DEPTH];
  logic [DEPTH-1:0]    r_lmem;
  logic [PW-1:0]       r_wr, r_rd;
  logic [CW-1:0]       r_cnt;
  logic                r_ovf;

  // A start cycle that also carries en is already step 0, so the step logic
  // looks through the IDLE->CAPTURE transition instead of waiting a cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_go   = (r_state == IDLE) && start && (rows != '0);
    w_scur = w_go ? '0 : r_s;
    w_m    = w_go ? rows : r_m;
    w_step = ((r_state == CAPTURE) || w_go) && en;
    w_push = w_step && (w_scur >= NM1);
    w_last = w_push && ((w_scur + SW'(1)) == (SW'(w_m) + NM1));
    case (r_state)
      IDLE:    if (w_go && !w_last) w_state_nxt = CAPTURE;
      CAPTURE: if (w_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s <= '0;
      r_m <= '0;
    end else begin
      if (w_step) r_s <= w_scur + SW'(1);
      if (w_go)   r_m <= rows;
    end
  end

  // Column j waits N-1-j steps; the shifters run on every en so they stay
  // aligned with the array even between tiles.
  for (genvar j = 0; j < N; j++) begin : g_col
    if (j < N - 1) begin : g_sh
      logic [ACC_W-1:0] r_sh [N-1-j];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int unsigned k = 0; k < N - 1 - j; k++) r_sh[k] <= '0;
        end else if (en) begin
          r_sh[0] <= down_in[j*ACC_W +: ACC_W];
          for (int unsigned k = 1; k < N - 1 - j; k++) r_sh[k] <= r_sh[k-1];
        end
      end
      assign w_row[j*ACC_W +: ACC_W] = r_sh[N-2-j];
    end else begin : g_live
      assign w_row[j*ACC_W +: ACC_W] = down_in[j*ACC_W +: ACC_W];
    end
  end

`ifdef SYSA_DRAIN_SAT_EN
  always_comb begin
    w_wdata = w_row;
    for (int unsigned j = 0; j < N; j++) begin
      if (w_row[j*ACC_W +: ACC_W] > ACC_W'(255)) w_wdata[j*ACC_W +: ACC_W] = ACC_W'(255);
    end
  end
`else
  assign w_wdata = w_row;
`endif

  assign w_full = (r_cnt == CW'(DEPTH));
  assign w_pop  = out_valid && out_ready;
  // When full, a simultaneous pop frees the slot being overwritten.
  assign w_wr   = w_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_lmem <= '0;
      r_wr   <= '0;
      r_rd   <= '0;
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr]  <= w_wdata;
        r_lmem[r_wr] <= w_last;
        r_wr         <= r_wr + PW'(1);
      end
      if (w_pop) r_rd <= r_rd + PW'(1);
      if (w_push && !w_wr) r_ovf <= 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign out_valid = (r_cnt != '0);
  assign out_data  = r_mem[r_rd];
  assign out_last  = r_lmem[r_rd];
  assign hold      = w_full;
  assign busy      = (r_state == CAPTURE) || (r_cnt != '0);
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_sysa_drain.sv
// Scoreboard bench for sysa_drain: rows are generated as a matrix, fed diagonally skewed, and expected rows queued up front.
module tb_sysa_drain;
  localparam int N = 3, ACC_W = 10, ROWS_W = 4, DEPTH = 4, W = N * ACC_W;

  logic clk = 1'b0;
  logic rst, en, start, out_valid, out_ready, out_last, hold, busy, ovf;
  logic [ROWS_W-1:0] rows;
  logic [W-1:0] down_in, out_data;

  typedef struct {
    logic [W-1:0] data;
    logic         last;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int ready_mode = 0;  // 0 low, 1 high, 2 random
  int tile[16][N];

  sysa_drain #(.N(N), .ACC_W(ACC_W), .ROWS_W(ROWS_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .rows(rows), .down_in(down_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .hold(hold), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [ACC_W-1:0] mdl(input int v);
`ifdef SYSA_DRAIN_SAT_EN
    return (v > 255) ? ACC_W'(255) : ACC_W'(v);
`else
    return ACC_W'(v);
`endif
  endfunction

  function automatic logic [W-1:0] row_of(input int r);
    logic [W-1:0] res;
    for (int j = 0; j < N; j++) res[j*ACC_W +: ACC_W] = mdl(tile[r][j]);
    return res;
  endfunction

  task automatic fill_rand(input int m);
    for (int r = 0; r < m; r++)
      for (int j = 0; j < N; j++) tile[r][j] = $urandom_range(0, 1023);
  endtask

  // ready driver: sole writer of out_ready
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // monitor: a transfer happens at the next posedge when valid && ready
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("row_extra", out_valid, 1'b0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("row", {out_last, out_data}, {e.last, e.data});
        end
      end
    end
  end

  // Feed tile rows 0..m-1 skewed (column j of row r at step r+j) for lim steps.
  task automatic run_tile(input int m, input int keep, input int lim, input int gap_pct,
                          input bit gate, input bit chk_lat);
    int ts = 0;
    int cyc = 0;
    bit en_w;
    for (int r = 0; r < keep; r++) exp_q.push_back('{data: row_of(r), last: (r == m - 1)});
    @(posedge clk); #1;
    start = 1'b1;
    rows  = ROWS_W'(m);
    while (ts < lim && cyc < 400) begin
      en_w = ($urandom_range(0, 99) >= gap_pct);
      if (gate && hold) en_w = 1'b0;
      en = en_w;
      for (int j = 0; j < N; j++) begin
        int r;
        r = ts - j;
        if (en_w && r >= 0 && r < m) down_in[j*ACC_W +: ACC_W] = ACC_W'(tile[r][j]);
        else down_in[j*ACC_W +: ACC_W] = ACC_W'($urandom);
      end
      @(posedge clk); #1;
      if (en_w) ts++;
      cyc++;
      start = (gap_pct > 0) && ($urandom_range(0, 7) == 0);
      if (start) rows = ROWS_W'($urandom_range(1, 15));
      if (chk_lat) chk("lat_valid", out_valid, (ts >= N));
    end
    chk("tile_steps", ts, lim);
    start = 1'b0;
    en    = 1'b0;
  endtask

  task automatic drain();
    int b = 0;
    ready_mode = 1;
    while (exp_q.size() != 0 && b < 500) begin
      @(posedge clk);
      b++;
    end
    chk("drain_empty", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("idle_valid", out_valid, 1'b0);
    chk("idle_busy", busy, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; en = 1'b0; start = 1'b0; rows = '0; down_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, '0);
    chk("rst_last", out_last, 1'b0);
    chk("rst_hold", hold, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    rst = 1'b0;

    // start with rows=0 is ignored
    start = 1'b1; rows = '0; en = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; en = 1'b0;
    chk("rows0_busy", busy, 1'b0);

    // basic M=2 tile
    ready_mode = 1;
    tile[0][0] = 1; tile[0][1] = 2; tile[0][2] = 3;
    tile[1][0] = 4; tile[1][1] = 5; tile[1][2] = 6;
    run_tile(2, 2, 2 + N - 1, 0, 1'b0, 1'b1);
    drain();

    // backpressure with controller gating en on hold
    ready_mode = 0;
    fill_rand(6);
    fork
      run_tile(6, 6, 6 + N - 1, 0, 1'b1, 1'b0);
      begin
        repeat (20) @(posedge clk);
        #1;
        chk("hold_full", hold, 1'b1);
        chk("ovf_gated", ovf, 1'b0);
        chk("busy_stalled", busy, 1'b1);
        ready_mode = 1;
      end
    join
    drain();
    chk("ovf_after_gated", ovf, 1'b0);

    // overflow: en not gated, last two rows dropped
    ready_mode = 0;
    fill_rand(6);
    run_tile(6, DEPTH, 6 + N - 1, 0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("ovf_set", ovf, 1'b1);
    chk("ovf_hold", hold, 1'b1);
    drain();
    chk("ovf_sticky", ovf, 1'b1);
    do_reset();
    chk("ovf_cleared", ovf, 1'b0);

    // en gaps inside an M=3 tile, then random tiles
    ready_mode = 2;
    fill_rand(3);
    run_tile(3, 3, 3 + N - 1, 40, 1'b1, 1'b0);
    drain();
    for (int t = 0; t < 15; t++) begin
      int m;
      m = $urandom_range(1, 15);
      fill_rand(m);
      ready_mode = 2;
      run_tile(m, m, m + N - 1, $urandom_range(0, 50), 1'b1, 1'b0);
      drain();
    end
    chk("ovf_random", ovf, 1'b0);

    // reset mid-capture with two rows queued
    ready_mode = 0;
    fill_rand(4);
    run_tile(4, 0, 4, 0, 1'b0, 1'b0);
    chk("mid_valid", out_valid, 1'b1);
    chk("mid_busy", busy, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_busy", busy, 1'b0);
    chk("flush_hold", hold, 1'b0);
    ready_mode = 1;
    fill_rand(1);
    run_tile(1, 1, N, 0, 1'b0, 1'b0);
    drain();

    // saturation row {300,255,0}
    tile[0][0] = 300; tile[0][1] = 255; tile[0][2] = 0;
    run_tile(1, 1, N, 0, 1'b0, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
